// File: rtl/cel_cfg.sv
// Serially configured fabric routing/logic cell: per-output source selects plus one K-input LUT.
// Optional CEL_CFG_READBACK_EN adds cfg_rd to copy the active config back into the scan shadow.
module cel_cfg #(
    parameter int unsigned SB_W  = 6,
    parameter int unsigned CB_W  = 2,
    parameter int unsigned LUT_K = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_en,
    input  logic            cfg_din,
    input  logic            cfg_commit,
`ifdef CEL_CFG_READBACK_EN
    input  logic            cfg_rd,
`endif
    output logic            cfg_dout,
    output logic            cfg_full,
    output logic            cfg_loaded,
    output logic            cfg_err,
    input  logic [SB_W-1:0] sbi,
    input  logic [CB_W-1:0] cbi,
    output logic [SB_W-1:0] sbo,
    output logic [CB_W-1:0] cbo
);
    localparam int unsigned NIN   = SB_W + CB_W;
    localparam int unsigned NSRC  = NIN + 1;
    localparam int unsigned SEL_W = $clog2(NSRC + 1);
    localparam int unsigned SRC_N = 2 ** SEL_W;
    localparam int unsigned LUT_N = 2 ** LUT_K;
    localparam int unsigned SEL_BITS = NIN * SEL_W;
    localparam int unsigned CFG_W = SEL_BITS + LUT_N + 1;
    localparam int unsigned CNT_W = $clog2(CFG_W + 1);

    // Reset config: every select all ones (drives 0), LUT table cleared, bypass off.
    localparam logic [CFG_W-1:0] ACTIVE_RST = CFG_W'({SEL_BITS{1'b1}});

    typedef enum logic [1:0] {EMPTY, LOADING, FULL} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CFG_W-1:0] shadow;
    logic [CFG_W-1:0] active;
    logic             lut_q;
    logic             rd_go;

`ifdef CEL_CFG_READBACK_EN
    assign rd_go = cfg_rd & ~cfg_en & ~cfg_commit;
`else
    assign rd_go = 1'b0;
`endif

    // Scan shadow, bit counter FSM and atomic commit into the active register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            cnt        <= '0;
            shadow     <= '0;
            active     <= ACTIVE_RST;
            cfg_loaded <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_en) begin
                shadow <= {shadow[CFG_W-2:0], cfg_din};
                if (state != FULL) begin
                    cnt   <= cnt + CNT_W'(1);
                    state <= (cnt == CNT_W'(CFG_W - 1)) ? FULL : LOADING;
                end
                if (cfg_commit) begin
                    cfg_err <= 1'b1;
                end
            end else if (cfg_commit) begin
                if (state == FULL) begin
                    active     <= shadow;
                    cnt        <= '0;
                    state      <= EMPTY;
                    cfg_loaded <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (rd_go) begin
                shadow <= active;
                cnt    <= CNT_W'(CFG_W);
                state  <= FULL;
            end
        end
    end

    assign cfg_full = (state == FULL);
    assign cfg_dout = shadow[CFG_W-1];

    logic [NIN-1:0]   in_all;
    logic [LUT_K-1:0] lut_addr;
    logic [LUT_N-1:0] lut_table;
    logic             lut_bypass;
    logic             lut_comb;
    logic             lut_out;
    logic [SRC_N-1:0] src;

    assign in_all     = {cbi, sbi};
    assign lut_addr   = in_all[LUT_K-1:0];
    assign lut_table  = active[SEL_BITS +: LUT_N];
    assign lut_bypass = active[CFG_W-1];
    assign lut_comb   = lut_table[lut_addr];
    assign lut_out    = lut_bypass ? lut_comb : lut_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_q <= 1'b0;
        end else begin
            lut_q <= lut_comb;
        end
    end

    // Source vector padded to 2^SEL_W so out-of-range selects read a zero bit.
    assign src = SRC_N'({lut_out, in_all});

    for (genvar j = 0; j < SB_W; j++) begin : g_sbo
        assign sbo[j] = src[active[j*SEL_W +: SEL_W]];
    end

    for (genvar j = 0; j < CB_W; j++) begin : g_cbo
        assign cbo[j] = src[active[(SB_W+j)*SEL_W +: SEL_W]];
    end

endmodule
